spi_xfer_ctrl: RTL
==================

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 The block SHALL have parameter SPI_CHAR_LEN_BITS, default 7, meaning the width of char_len; the maximum transfer is 2^SPI_CHAR_LEN_BITS bits.
REQ-002 The block SHALL have parameter SPI_SS_NB, default 8, meaning the number of slave-select lines.
REQ-003 The block SHALL have port wb_clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port wb_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port go, input, 1 bit: transfer start request, sampled only in IDLE.
REQ-006 The block SHALL have port char_len, input, SPI_CHAR_LEN_BITS bits: bits per transfer; 0 means 2^SPI_CHAR_LEN_BITS.
REQ-007 The block SHALL have port ss_sel, input, SPI_SS_NB bits: slave-select mask, 1 = selected.
REQ-008 The block SHALL have port ss_auto, input, 1 bit: 1 = assert selects only while tip is high; 0 = assert them continuously.
REQ-009 The block SHALL have port ie, input, 1 bit: interrupt enable.
REQ-010 The block SHALL have port int_ack, input, 1 bit: interrupt clear pulse.
REQ-011 The block SHALL have ports pos_edge and neg_edge, inputs, 1 bit each: one-cycle pre-edge pulses from the SPI clock generator, one cycle before sclk rises and one cycle before sclk falls respectively.
REQ-012 The block SHALL have port tip, output, 1 bit: transfer in progress, driven to the clock generator.
REQ-013 The block SHALL have port last_clk, output, 1 bit: final bit in flight, driven to the clock generator.
REQ-014 The block SHALL have port bit_cnt, output, SPI_CHAR_LEN_BITS+1 bits: bits remaining.
REQ-015 The block SHALL have ports tx_shift and rx_sample, outputs, 1 bit each: shift-register strobes.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle end-of-transfer pulse.
REQ-017 The block SHALL have port irq, output, 1 bit: sticky interrupt.
REQ-018 The block SHALL have port ss_pad_o, output, SPI_SS_NB bits: slave selects, active low.

Function
REQ-019 The FSM SHALL have three states, IDLE, RUN and FINISH; all outputs except the strobes and ss_pad_o SHALL be registered.
REQ-020 IDLE with go=1 -> RUN next cycle, with bit_cnt <= (char_len==0 ? 2^SPI_CHAR_LEN_BITS : char_len) and tip <= 1 in the same edge.
REQ-021 go SHALL be ignored in RUN and FINISH, with no queuing.
REQ-022 In RUN, each neg_edge pulse SHALL decrement bit_cnt by 1; pos_edge SHALL never change bit_cnt.
REQ-023 last_clk SHALL be 1 exactly when the state is RUN and bit_cnt==1, and 0 otherwise.
REQ-024 A neg_edge in RUN with bit_cnt==1 SHALL set bit_cnt to 0 and move to FINISH; tip SHALL remain 1 in FINISH so the clock generator completes the final falling edge.
REQ-025 FINISH SHALL last exactly 1 cycle, then go to IDLE with tip <= 0 and done=1 for that one cycle.
REQ-026 irq SHALL be set on the same edge done is asserted when ie=1, and cleared by int_ack; set SHALL win over a simultaneous int_ack.
REQ-027 tx_shift SHALL equal neg_edge & (state==RUN), and rx_sample SHALL equal pos_edge & (state==RUN), both combinational.
REQ-028 Simultaneous pos_edge and neg_edge is illegal input; if it occurs, the neg_edge action SHALL apply and rx_sample SHALL still follow REQ-027.
REQ-029 Edge pulses arriving in IDLE or FINISH SHALL be ignored.
REQ-030 ss_pad_o SHALL equal ~(ss_sel & {SPI_SS_NB{ss_auto ? tip : 1'b1}}).
REQ-031 bit_cnt SHALL never wrap below 0, and its maximum load value SHALL be representable in SPI_CHAR_LEN_BITS+1 bits.

Reset
REQ-032 wb_rst=1 SHALL immediately, regardless of clock, force: state=IDLE, tip=0, last_clk=0, bit_cnt=0, done=0, irq=0.
REQ-033 A reset asserted mid-transfer SHALL abort the transfer with no done pulse and no irq.
REQ-034 After reset deassertion, the first go SHALL start a transfer normally.

Verification
REQ-035 Scenario: char_len=8, ie=1, go pulse, clock generator model at divider=1 -> exactly 8 neg_edge decrements, last_clk high only while bit_cnt==1, one done pulse, irq=1, tip falls one cycle after FINISH.
REQ-036 Scenario: char_len=0 -> bit_cnt loads 128, and 128 tx_shift and 128 rx_sample strobes occur before done.
REQ-037 Scenario: char_len=1 -> last_clk asserted from the first RUN cycle, and one tx_shift precedes done.
REQ-038 Scenario: go pulsed again during RUN and during FINISH -> ignored; bit count and single done are unchanged.
REQ-039 Scenario: wb_rst asserted at bit_cnt=3 -> all outputs reset asynchronously, ss_pad_o=all-ones with ss_auto=1, no done and no irq.
REQ-040 Scenario: int_ack coincident with done while ie=1 -> irq=1; int_ack one cycle later -> irq=0; ss_auto=0 with ss_sel=8'h05 -> ss_pad_o=8'hFA in IDLE.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: counts bits against the clock generator's pre-edge
// pulses, drives tip/last_clk back to it and raises done/irq at the end.
module spi_xfer_ctrl #(
    parameter int SPI_CHAR_LEN_BITS = 7,
    parameter int SPI_SS_NB         = 8
) (
    input  logic                         wb_clk_in,
    input  logic                         wb_rst,
    input  logic                         go,
    input  logic [SPI_CHAR_LEN_BITS-1:0] char_len,
    input  logic [SPI_SS_NB-1:0]         ss_sel,
    input  logic                         ss_auto,
    input  logic                         ie,
    input  logic                         int_ack,
    input  logic                         pos_edge,
    input  logic                         neg_edge,
    output logic                         tip,
    output logic                         last_clk,
    output logic [SPI_CHAR_LEN_BITS:0]   bit_cnt,
    output logic                         tx_shift,
    output logic                         rx_sample,
    output logic                         done,
    output logic                         irq,
    output logic [SPI_SS_NB-1:0]         ss_pad_o
);

    localparam int CNT_W = SPI_CHAR_LEN_BITS + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {1'b1, {SPI_CHAR_LEN_BITS{1'b0}}};

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_load;
    logic             tip_nxt;
    logic             done_nxt;
    logic             irq_nxt;
    logic             last_nxt;

    // A zero length field encodes the largest transfer.
    assign cnt_load = (char_len == '0) ? CNT_MAX : {1'b0, char_len};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        tip_nxt   = tip;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = RUN;
                    cnt_nxt   = cnt_load;
                    tip_nxt   = 1'b1;
                end
            end
            RUN: begin
                // neg_edge alone moves the count, which also settles the illegal both-edges case.
                if (neg_edge) begin
                    if (bit_cnt <= CNT_ONE) begin
                        cnt_nxt   = CNT_ZERO;
                        state_nxt = FINISH;
                    end else begin
                        cnt_nxt = bit_cnt - CNT_ONE;
                    end
                end
            end
            FINISH: begin
                state_nxt = IDLE;
                tip_nxt   = 1'b0;
                done_nxt  = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                tip_nxt   = 1'b0;
            end
        endcase
    end

    assign last_nxt = (state_nxt == RUN) && (cnt_nxt == CNT_ONE);

    // A new interrupt takes priority over a coincident acknowledge.
    assign irq_nxt = (done_nxt && ie) ? 1'b1 : (int_ack ? 1'b0 : irq);

    always_ff @(posedge wb_clk_in or posedge wb_rst) begin
        if (wb_rst) begin
            state    <= IDLE;
            bit_cnt  <= CNT_ZERO;
            tip      <= 1'b0;
            last_clk <= 1'b0;
            done     <= 1'b0;
            irq      <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= cnt_nxt;
            tip      <= tip_nxt;
            last_clk <= last_nxt;
            done     <= done_nxt;
            irq      <= irq_nxt;
        end
    end

    assign tx_shift  = neg_edge & (state == RUN);
    assign rx_sample = pos_edge & (state == RUN);

    assign ss_pad_o = ~(ss_sel & {SPI_SS_NB{ss_auto ? tip : 1'b1}});

endmodule
